// File: rtl/rtc_seq_pkg.sv
// Shared definitions for the RTC address sequencer: register-address table,
// sequencer FSM states and the index-to-address lookup helper.
package rtc_seq_pkg;

    localparam int RTC_DEPTH = 11;
    localparam int RTC_TBL_W = 8;

    localparam logic [RTC_TBL_W-1:0] RTC_ADDR_TABLE [RTC_DEPTH] = '{
        8'h00, 8'h64, 8'h65, 8'h66, 8'h67,
        8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_DONE
    } rtc_seq_state_e;

    // Indices beyond the populated table read as address 0x00.
    function automatic logic [RTC_TBL_W-1:0] rtc_table_entry(input int idx);
        logic [RTC_TBL_W-1:0] entry;
        entry = '0;
        for (int k = 0; k < RTC_DEPTH; k++) begin
            if (idx == k) begin
                entry = RTC_ADDR_TABLE[k];
            end
        end
        return entry;
    endfunction

endpackage

// File: rtl/rtc_addr_sequencer_if.sv
// Address request channel between the sequencer (master) and the RTC bus
// controller (slave): valid/ready handshake carrying address and table index.
interface rtc_addr_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 4
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [IDX_W-1:0]  req_idx;

    modport master (
        output req_valid,
        output req_addr,
        output req_idx,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_idx,
        output req_ready
    );

endinterface

// File: rtl/rtc_addr_rom.sv
// Registered index-to-address lookup over the RTC register table; entries are
// zero-extended or truncated to ADDR_W, unpopulated indices read 0.
module rtc_addr_rom
    import rtc_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [ADDR_W-1:0] rom_mem [ENTRIES];
    logic [ADDR_W-1:0] addr_q;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_rom
        assign rom_mem[gi] = ADDR_W'(rtc_table_entry(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= rom_mem[idx_i];
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/rtc_addr_sequencer.sv
// Walks table indices [first_idx, last_idx] and issues one RTC register address
// per valid/ready transfer. Optional macro RTC_SEQ_REPEAT_EN adds the cont input.
module rtc_addr_sequencer
    import rtc_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = RTC_DEPTH,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
`ifdef RTC_SEQ_REPEAT_EN
    input  logic             cont,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    rtc_addr_sequencer_if.master req
);

    rtc_seq_state_e    state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
`ifdef RTC_SEQ_REPEAT_EN
    logic [IDX_W-1:0]  first_q, first_d;
`endif
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              range_ok;
    logic [ADDR_W-1:0] rom_addr;

    assign range_ok = (first_idx <= last_idx) && (int'(last_idx) < DEPTH);

    rtc_addr_rom #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_rom (
        .clk    (clk),
        .reset  (reset),
        .idx_i  (idx_q),
        .addr_o (rom_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
`ifdef RTC_SEQ_REPEAT_EN
            first_q <= '0;
`endif
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef RTC_SEQ_REPEAT_EN
            first_q <= first_d;
`endif
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef RTC_SEQ_REPEAT_EN
        first_d = first_q;
`endif
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (range_ok) begin
                        idx_d   = first_idx;
                        last_d  = last_idx;
`ifdef RTC_SEQ_REPEAT_EN
                        first_d = first_idx;
`endif
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // The ROM registers the address for idx_q during this cycle.
            ST_LOAD: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (req.req_ready) begin
                    if (idx_q == last_q) begin
                        done_d = 1'b1;
`ifdef RTC_SEQ_REPEAT_EN
                        if (cont) begin
                            idx_d   = first_q;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req.req_valid = (state_q == ST_ISSUE);
    assign req.req_addr  = rom_addr;
    assign req.req_idx   = idx_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_rtc_addr_sequencer.sv
// Bench for rtc_addr_sequencer: transfer-level scoreboard checked every cycle
// plus directed scenarios with literal expectations.
module tb_rtc_addr_sequencer;

    localparam int ADDR_W = 8;
    localparam int IDX_W  = 4;
    localparam int DEPTH  = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] last_idx;
    logic             busy;
    logic             done;
    logic             err;
`ifdef RTC_SEQ_REPEAT_EN
    logic             cont;
`endif

    rtc_addr_sequencer_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

    rtc_addr_sequencer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
`ifdef RTC_SEQ_REPEAT_EN
        .cont      (cont),
`endif
        .busy      (busy),
        .done      (done),
        .err       (err),
        .req       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: the address table as a plain array and a queue of the
    // transfers the bus controller must see, in order.
    typedef struct {
        int idx;
        int addr;
    } xfer_t;

    int    tbl [DEPTH] = '{'h00, 'h64, 'h65, 'h66, 'h67, 'h33, 'h34, 'h35, 'h36, 'h37, 'h38};
    xfer_t exp_q [$];

    function automatic int model_addr(input int i);
        if (i < DEPTH) return tbl[i] & ((1 << ADDR_W) - 1);
        return 0;
    endfunction

    task automatic push_range(input int f, input int l);
        xfer_t x;
        for (int i = f; i <= l; i++) begin
            x.idx  = i;
            x.addr = model_addr(i);
            exp_q.push_back(x);
        end
    endtask

    // Monitor state
    logic [7:0] obs_addr [$];
    int  got_done = 0, got_err = 0, n_valid = 0, cnt34 = 0, acc2 = 0;
    int  first_valid_cyc = -1, accept_cyc = 0, done_cyc = 0, busy_fall_cyc = 0, busy_falls = 0;
    bit  busy_prev = 1'b0;
    bit  any_busy = 1'b0;

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            busy_prev = 1'b0;
        end else begin
            if (busy) any_busy = 1'b1;
            if (!busy && busy_prev) begin
                busy_falls++;
                busy_fall_cyc = cyc;
            end
            busy_prev = busy;
            if (bus.req_valid) begin
                n_valid++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.req_addr == 8'h34) cnt34++;
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 32'(bus.req_valid), 0);
                end else begin
                    check("req_idx", 32'(bus.req_idx), exp_q[0].idx);
                    check("req_addr", 32'(bus.req_addr), exp_q[0].addr);
                    check("busy_with_valid", 32'(busy), 1);
                    if (bus.req_ready) begin
                        $display("xfer idx=%0d addr=0x%02h cycle=%0d", bus.req_idx, bus.req_addr, cyc);
                        obs_addr.push_back(bus.req_addr);
                        if (bus.req_idx == 2) acc2++;
                        accept_cyc = cyc;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                got_done++;
                done_cyc = cyc;
                check("done_excl_valid", 32'(bus.req_valid), 0);
            end
            if (err) begin
                got_err++;
                check("err_while_idle", 32'(busy), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int f, input int l);
        start     = 1'b1;
        first_idx = IDX_W'(f);
        last_idx  = IDX_W'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_quiet(input string nm, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_drained"}, exp_q.size(), 0);
        tick();
    endtask

    task automatic check_obs(input string nm, input logic [7:0] lit [$]);
        check({nm, "_count"}, obs_addr.size(), lit.size());
        for (int k = 0; k < lit.size() && k < obs_addr.size(); k++) begin
            check($sformatf("%s_addr%0d", nm, k), 32'(obs_addr[k]), 32'(lit[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0, e0, nv0, bf0, found;
        logic [7:0] lit [$];

        reset         = 1'b1;
        start         = 1'b0;
        first_idx     = '0;
        last_idx      = '0;
        bus.req_ready = 1'b0;
`ifdef RTC_SEQ_REPEAT_EN
        cont          = 1'b0;
`endif
        repeat (3) tick();
        check("rst_valid", 32'(bus.req_valid), 0);
        check("rst_addr",  32'(bus.req_addr), 0);
        check("rst_idx",   32'(bus.req_idx), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_err",   32'(err), 0);
        reset = 1'b0;
        tick();

        // Full sweep 0..10 with the controller always ready
        bus.req_ready   = 1'b1;
        obs_addr.delete();
        first_valid_cyc = -1;
        d0 = got_done;
        push_range(0, 10);
        c0 = cyc;
        pulse_start(0, 10);
        wait_quiet("sweep", 100);
        check("sweep_first_valid_lat", first_valid_cyc - c0, 2);
        check("sweep_done_lat", done_cyc - accept_cyc, 1);
        check("sweep_busy_fall_lat", busy_fall_cyc - done_cyc, 1);
        check("sweep_done_count", got_done - d0, 1);
        lit = '{8'h00, 8'h64, 8'h65, 8'h66, 8'h67, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        check_obs("sweep", lit);

        // Backpressure: hold ready low for three cycles while idx 6 is offered
        obs_addr.delete();
        cnt34 = 0;
        d0 = got_done;
        push_range(5, 7);
        pulse_start(5, 7);
        begin
            int hold;
            hold = 0;
            for (int n = 0; n < 60 && (busy || exp_q.size() != 0); n++) begin
                if (bus.req_valid && bus.req_idx == 4'd6 && hold < 3) begin
                    bus.req_ready = 1'b0;
                    hold++;
                end else begin
                    bus.req_ready = 1'b1;
                end
                tick();
            end
        end
        bus.req_ready = 1'b1;
        wait_quiet("bp", 20);
        check("bp_hold_cycles_34", cnt34, 4);
        check("bp_done_count", got_done - d0, 1);
        lit = '{8'h33, 8'h34, 8'h35};
        check_obs("bp", lit);

        // Rejected starts: reversed range, then last beyond the table
        e0 = got_err;
        d0 = got_done;
        nv0 = n_valid;
        any_busy = 1'b0;
        pulse_start(7, 3);
        tick();
        pulse_start(0, 11);
        tick();
        tick();
        check("rej_err_count", got_err - e0, 2);
        check("rej_busy_seen", 32'(any_busy), 0);
        check("rej_valid_seen", n_valid - nv0, 0);
        check("rej_done_count", got_done - d0, 0);

        // Single entry, with a second start presented while the address is pending
        obs_addr.delete();
        d0 = got_done;
        e0 = got_err;
        push_range(4, 4);
        pulse_start(4, 4);
        bus.req_ready = 1'b0;
        tick();
        check("single_valid_pending", 32'(bus.req_valid), 1);
        pulse_start(0, 10);
        bus.req_ready = 1'b1;
        wait_quiet("single", 30);
        tick();
        check("single_done_count", got_done - d0, 1);
        check("single_err_count", got_err - e0, 0);
        check("single_idle_after", 32'(busy), 0);
        lit = '{8'h67};
        check_obs("single", lit);

        // Reset while idx 8 of range 5..10 is on the bus
        d0 = got_done;
        bus.req_ready = 1'b1;
        push_range(5, 10);
        pulse_start(5, 10);
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            if (bus.req_valid && bus.req_idx == 4'd8) found = 1;
            else tick();
        end
        check("rstmid_reached_idx8", found, 1);
        reset = 1'b1;
        bus.req_ready = 1'b0;
        exp_q.delete();
        tick();
        check("rstmid_valid", 32'(bus.req_valid), 0);
        check("rstmid_addr",  32'(bus.req_addr), 0);
        check("rstmid_idx",   32'(bus.req_idx), 0);
        check("rstmid_busy",  32'(busy), 0);
        check("rstmid_done",  32'(done), 0);
        check("rstmid_err",   32'(err), 0);
        reset = 1'b0;
        bus.req_ready = 1'b1;
        tick();
        tick();
        check("rstmid_no_done", got_done - d0, 0);
        obs_addr.delete();
        push_range(1, 1);
        pulse_start(1, 1);
        wait_quiet("after_rst", 30);
        lit = '{8'h64};
        check_obs("after_rst", lit);

`ifdef RTC_SEQ_REPEAT_EN
        // Repeat: range 1..2, continue after the first two passes, stop after the third
        obs_addr.delete();
        d0 = got_done;
        bf0 = busy_falls;
        acc2 = 0;
        repeat (3) push_range(1, 2);
        cont = 1'b1;
        pulse_start(1, 2);
        for (int n = 0; n < 100 && (busy || exp_q.size() != 0); n++) begin
            cont = (acc2 < 2);
            tick();
        end
        cont = 1'b0;
        wait_quiet("rep", 20);
        check("rep_done_count", got_done - d0, 3);
        check("rep_busy_falls", busy_falls - bf0, 1);
        lit = '{8'h64, 8'h65, 8'h64, 8'h65, 8'h64, 8'h65};
        check_obs("rep", lit);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
